mult_q3p14: RTL and testbench
=============================

Name: mult_q3p14

Overview:
- Registered signed fixed-point multiplier in the GRNG core datapath.
- Multiplies the rightmost-coordinate operand by the truncated-value operand.
- Both operands are Q3.14; the product is full-precision Q7.28.
- Output is registered with one clock of latency.

Parameters:
- IN_W, 18, operand width in bits (signed two's complement, Q3.14 at default).
- OUT_W, 36, product width; must equal 2*IN_W (Q7.28 at default).
- PIPE, 1, number of register stages from operand to output; default 1 is the required configuration.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- rmost_coord  input  IN_W  signed Q3.14 operand A.
- trunc_value  input  IN_W  signed Q3.14 operand B.
- mult_value  output  OUT_W  signed Q7.28 product, registered.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Arithmetic:
  - mult_value = rmost_coord * trunc_value, both operands treated as signed two's complement.
  - Exact full-width product: no rounding, truncation, or saturation.
  - The binary point moves from bit 14 (inputs) to bit 28 (output).
- Range: every 18x18 signed product fits in 36 bits, so there is no overflow.
  - The extreme case (-8.0) * (-8.0) = +64.0 = 36'h4_0000_0000 is representable.
- Latency:
  - Operands sampled at rising edge N appear on mult_value immediately after edge N (PIPE=1).
  - They remain stable until the next edge.
  - For PIPE>1, latency is PIPE edges with one result per cycle.
- Throughput: new operands are accepted every cycle. There is no handshake and no valid signal.
- Reset:
  - While rst=1 at a rising edge, every pipeline register and mult_value load 0.
  - rst takes priority over the operands.
  - The first edge with rst=0 loads the product of the operands present at that edge.
  - Reset asserted mid-stream discards all in-flight products.
- Before the first reset or first clock, the output is undefined; the bench must not check it.
- No combinational path from inputs to mult_value.
- Sign handling:
  - Both operands are sign-extended to OUT_W before multiplying, or a signed multiply operator is used.
  - An unsigned multiply is a defect; the cases with negative operands expose it.

Test Plan:
- rst=1 for 2 edges with arbitrary operands -> mult_value=36'h0; release rst with A=18'h0_4000 (1.0), B=18'h0_4000 -> next edge mult_value=36'h0_1000_0000 (1.0).
- A=18'h2_0000 (-8.0), B=18'h2_0000 (-8.0) -> after next edge mult_value=36'h4_0000_0000 (+64.0); A=18'h2_0000, B=18'h0_0000 -> 36'h0 (0.0).
- A=18'h2_0000 (-8.0), B=18'h1_FFFF (7.99993896484375) -> 36'hC_0002_0000 (-63.99951171875); A=B=18'h1_FFFF -> 36'h3_FFFC_0001 (63.99902343...).
- A=18'h0_0001 (2^-14), B=18'h3_FFFF (-2^-14) -> 36'hF_FFFF_FFFF (-2^-28), confirming sign extension.
- Back-to-back: change operands every cycle for 1000 random signed pairs -> each output equals the exact signed product of the operands one edge earlier, compared against a 36-bit reference model.
- Assert rst mid-stream for one edge -> mult_value=0 on that edge; correct products resume on the following edge.

Source files
------------

// File: rtl/mult_q3p14.sv
// mult_q3p14 -- registered signed fixed-point multiplier for the GRNG datapath.
//
// Multiplies the rightmost-coordinate operand by the truncated-value operand.
// Both operands are signed two's complement Q3.14. The product is the exact
// full-width Q7.28 result, with no rounding, truncation or saturation. The
// binary point moves from bit 14 to bit 28.
//
// Interface contract: there is no handshake. A new operand pair is accepted
// on every rising edge of clk. The matching product appears PIPE edges later,
// and each result holds until the next edge.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high; clears every stage
//   rmost_coord  IN_W-bit signed Q3.14 operand A
//   trunc_value  IN_W-bit signed Q3.14 operand B
//   mult_value   OUT_W-bit signed Q7.28 product, registered
//
// Parameters:
//   IN_W   operand width (18 for Q3.14)
//   OUT_W  product width; must equal 2*IN_W so every product fits
//   PIPE   register stages from operand to output (>= 1)

module mult_q3p14 #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 36,
  parameter int PIPE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  rmost_coord,
  input  logic [IN_W-1:0]  trunc_value,
  output logic [OUT_W-1:0] mult_value
);

  // Operands are reinterpreted as signed. Assigning them to wider signed
  // nets sign-extends them, so the OUT_W-bit multiply is exact for negative
  // inputs. The product of two IN_W-bit values always fits in 2*IN_W bits.
  logic signed [IN_W-1:0]  a_s;
  logic signed [IN_W-1:0]  b_s;
  logic signed [OUT_W-1:0] a_ext;
  logic signed [OUT_W-1:0] b_ext;
  logic signed [OUT_W-1:0] prod;

  assign a_s   = rmost_coord;
  assign b_s   = trunc_value;
  assign a_ext = a_s;
  assign b_ext = b_s;
  assign prod  = a_ext * b_ext;

  // Stage 0 captures the product. Later stages only delay it.
  // Reset clears every stage, so any product still in flight is discarded.
  logic [OUT_W-1:0] stage [PIPE];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= prod;
      for (int i = 1; i < PIPE; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign mult_value = stage[PIPE-1];

endmodule

// File: tb/tb_mult_q3p14.sv
// tb_mult_q3p14 -- directed and random checks for mult_q3p14 (PIPE=1).

module tb_mult_q3p14;

  localparam int IN_W  = 18;
  localparam int OUT_W = 36;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [IN_W-1:0]  rmost_coord = '0;
  logic [IN_W-1:0]  trunc_value = '0;
  logic [OUT_W-1:0] mult_value;

  always #5 clk = ~clk;

  mult_q3p14 #(.IN_W(IN_W), .OUT_W(OUT_W), .PIPE(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .rmost_coord (rmost_coord),
    .trunc_value (trunc_value),
    .mult_value  (mult_value)
  );

  // ---------------- scoreboard ----------------
  int vec_cnt = 0;
  int err_cnt = 0;
  logic [OUT_W-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [OUT_W-1:0] got,
                           input logic [OUT_W-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: multiply the magnitudes unsigned, then apply the sign.
  function automatic logic [OUT_W-1:0] ref_mul(input logic [IN_W-1:0] a,
                                               input logic [IN_W-1:0] b);
    logic [IN_W-1:0]  ma;
    logic [IN_W-1:0]  mb;
    logic [OUT_W-1:0] m;
    ma = a[IN_W-1] ? (~a + 18'd1) : a;
    mb = b[IN_W-1] ? (~b + 18'd1) : b;
    m  = {18'd0, ma} * {18'd0, mb};
    return (a[IN_W-1] ^ b[IN_W-1]) ? (~m + 36'd1) : m;
  endfunction

  // ---------------- driver ----------------
  // Drive on the falling edge, let one rising edge pass, then sample 1 ns later.
  task automatic step(input logic r, input logic [IN_W-1:0] a,
                      input logic [IN_W-1:0] b, input logic [OUT_W-1:0] exp,
                      input string tag);
    @(negedge clk);
    rst = r;
    rmost_coord = a;
    trunc_value = b;
    @(posedge clk);
    #1;
    check_val(tag, mult_value, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held for two edges with non-zero operands present.
    step(1'b1, 18'h1_2345, 18'h2_ABCD, 36'h0, "reset_edge1");
    step(1'b1, 18'h3_FFFF, 18'h1_FFFF, 36'h0, "reset_edge2");

    // Directed vectors with hand-computed products.
    step(1'b0, 18'h0_4000, 18'h0_4000, 36'h0_1000_0000, "one_x_one");
    step(1'b0, 18'h2_0000, 18'h2_0000, 36'h4_0000_0000, "neg8_x_neg8");
    step(1'b0, 18'h2_0000, 18'h0_0000, 36'h0,           "neg8_x_zero");
    step(1'b0, 18'h2_0000, 18'h1_FFFF, 36'hC_0002_0000, "neg8_x_max");
    step(1'b0, 18'h1_FFFF, 18'h1_FFFF, 36'h3_FFFC_0001, "max_x_max");
    step(1'b0, 18'h0_0001, 18'h3_FFFF, 36'hF_FFFF_FFFF, "lsb_x_neglsb");
    step(1'b0, 18'h3_C000, 18'h0_8000, 36'hF_E000_0000, "neg1_x_two");
    step(1'b0, 18'h3_FFFF, 18'h3_FFFF, 36'h0_0000_0001, "neglsb_sq");

    // Mid-stream reset clears the output, then products resume.
    step(1'b1, 18'h1_FFFF, 18'h1_FFFF, 36'h0,           "mid_reset");
    step(1'b0, 18'h0_4000, 18'h3_C000, 36'hF_F000_0000, "after_reset");

    // Back-to-back random pairs, with new operands on every cycle.
    for (int i = 0; i < 1000; i++) begin
      logic [IN_W-1:0] a;
      logic [IN_W-1:0] b;
      a = 18'($urandom_range(0, 262143));
      b = 18'($urandom_range(0, 262143));
      @(negedge clk);
      rst = 1'b0;
      rmost_coord = a;
      trunc_value = b;
      exp_q.push_back(ref_mul(a, b));
      @(posedge clk);
      #1;
      check_val("random", mult_value, exp_q.pop_front());
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
